// File: rtl/stream_accumulator.sv
// stream_accumulator
//   Accumulates a packet of signed operand beats (add or subtract each beat)
//   and presents the packet result with a sticky overflow flag and a beat
//   count. Results are held until the consumer accepts them.
//
// Parameters
//   BITS      operand width (signed)
//   ACC_BITS  accumulator / result width, must exceed BITS
//   SATURATE  1 = clamp on overflow, 0 = two's-complement wrap
//   CNT_BITS  beat counter width (counter saturates at all-ones)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      operand beat handshake
//   in_data, in_sub, in_last operand, subtract select, final-beat marker
//   out_valid / out_ready    result handshake (out_valid high only in HOLD)
//   out_data, out_overflow,  registered packet result, sticky overflow,
//   out_count                beats accepted in the packet
module stream_accumulator #(
  parameter int BITS     = 16,
  parameter int ACC_BITS = 24,
  parameter int SATURATE = 1,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_sub,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_data,
  output logic                out_overflow,
  output logic [CNT_BITS-1:0] out_count
);

  if (ACC_BITS <= BITS) begin : g_bad_params
    $error("stream_accumulator: ACC_BITS must be greater than BITS");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic [CNT_BITS-1:0] count;
  logic                ovf;
  logic                ready_q;
  logic                valid_q;

  logic [ACC_BITS:0]   base;
  logic [ACC_BITS:0]   operand;
  logic [ACC_BITS:0]   sum;
  logic                sum_ovf;
  logic [ACC_BITS-1:0] next_acc;
  logic [CNT_BITS-1:0] next_count;
  logic                accept;

  assign accept = in_valid && ready_q;

  // One extra bit of headroom makes negating the most negative operand
  // exact and exposes overflow as a mismatch of the top two sum bits.
  always_comb begin
    base       = (state == IDLE) ? '0 : {acc[ACC_BITS-1], acc};
    operand    = {{(ACC_BITS+1-BITS){in_data[BITS-1]}}, in_data};
    sum        = in_sub ? (base - operand) : (base + operand);
    sum_ovf    = sum[ACC_BITS] ^ sum[ACC_BITS-1];
    next_acc   = sum[ACC_BITS-1:0];
    if (sum_ovf && (SATURATE != 0)) begin
      next_acc = sum[ACC_BITS] ? ACC_MIN : ACC_MAX;
    end
    next_count = count;
    if (state == IDLE) begin
      next_count = CNT_BITS'(1);
    end else if (!(&count)) begin
      next_count = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= next_acc;
            count <= next_count;
            ovf   <= ((state == IDLE) ? 1'b0 : ovf) | sum_ovf;
            if (in_last) begin
              state   <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state   <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The running accumulator doubles as the result register: it only moves
  // on accepted beats, so it is stable for the whole of HOLD.
  assign in_ready     = ready_q;
  assign out_valid    = valid_q;
  assign out_data     = acc;
  assign out_overflow = ovf;
  assign out_count    = count;

endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator
//   Drives a saturating and a wrapping stream_accumulator with identical
//   stimulus: a table of directed beats, hand-written corner sequences
//   (saturation/wrap, output stall, async reset) and 1000 random packets
//   checked against an integer-arithmetic reference model.
module tb_stream_accumulator;

  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;
  localparam longint SPAN = 16777216;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid, in_sub, in_last, out_ready;
  logic signed [15:0] in_data;
  logic               in_ready_s, in_ready_w, out_valid_s, out_valid_w;
  logic signed [23:0] out_data_s, out_data_w;
  logic               ovf_s, ovf_w;
  logic [7:0]         cnt_s, cnt_w;

  stream_accumulator #(.BITS(16), .ACC_BITS(24), .SATURATE(1), .CNT_BITS(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_overflow(ovf_s), .out_count(cnt_s)
  );

  stream_accumulator #(.BITS(16), .ACC_BITS(24), .SATURATE(0), .CNT_BITS(8)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_overflow(ovf_w), .out_count(cnt_w)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    bit     sub;
    int     data;
    bit     last;
    longint exp_data;
    longint exp_cnt;
  } vec_t;

  typedef struct {
    bit sub;
    int data;
  } beat_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum with clamp or wrap applied after every beat.
  function automatic void ref_result(input beat_t p[$], input bit sat,
                                     output longint res, output bit ovf,
                                     output longint cnt);
    longint a = 0;
    ovf = 1'b0;
    foreach (p[i]) begin
      a += p[i].sub ? -longint'(p[i].data) : longint'(p[i].data);
      if (a > MAXV || a < MINV) begin
        ovf = 1'b1;
        if (sat) a = (a > MAXV) ? MAXV : MINV;
        else     a = (a > MAXV) ? a - SPAN : a + SPAN;
      end
    end
    res = a;
    cnt = (p.size() > 255) ? 255 : p.size();
  endfunction

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_packet(input beat_t p[$], input bit gaps);
    longint rs, rw, cs, cw;
    bit     os, ow;
    int     n;
    for (int i = 0; i < p.size(); i++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        for (int b = 0; b < n; b++) begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          in_sub   = 1'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end
      chk("in_ready_before_beat", in_ready_s, 1);
      in_valid = 1'b1;
      in_sub   = p[i].sub;
      in_data  = 16'(p[i].data);
      in_last  = (i == p.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ref_result(p, 1'b1, rs, os, cs);
    ref_result(p, 1'b0, rw, ow, cw);
    chk("out_valid_sat", out_valid_s, 1);
    chk("out_valid_wrap", out_valid_w, 1);
    chk("out_data_sat", out_data_s, rs);
    chk("out_data_wrap", out_data_w, rw);
    chk("out_overflow_sat", ovf_s, os);
    chk("out_overflow_wrap", ovf_w, ow);
    chk("out_count_sat", cnt_s, cs);
    chk("out_count_wrap", cnt_w, cw);
    // Stall with junk offered; it must not be absorbed.
    n = gaps ? $urandom_range(0, 3) : 0;
    for (int s = 0; s < n; s++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      tick();
    end
    in_valid = 1'($urandom);
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
    consume();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_after_consume", out_valid_s, 0);
    chk("in_ready_after_consume", in_ready_s, 1);
    chk("no_beat_on_consume", out_data_s, rs);
  endtask

  vec_t  vecs[$];
  beat_t pkt[$];
  longint held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("reset_out_data", out_data_s, 0);
    chk("reset_out_count", cnt_s, 0);
    chk("reset_out_overflow", ovf_s, 0);
    chk("reset_out_valid", out_valid_s, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("in_ready_after_reset", in_ready_s, 1);

    // Directed beats: expected running result after each accepted beat.
    vecs = '{
      '{0, 100, 0, 100, 1}, '{0, 200, 0, 300, 2}, '{1, 50, 1, 250, 3},
      '{1, -32768, 1, 32768, 1},
      '{0, -32768, 0, -32768, 1}, '{0, -32768, 1, -65536, 2},
      '{1, 32767, 1, -32767, 1},
      '{0, 0, 1, 0, 1},
      '{0, 7, 0, 7, 1}, '{1, -3, 0, 10, 2}, '{0, -20, 1, -10, 3}
    };
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_sub   = vecs[i].sub;
      in_data  = 16'(vecs[i].data);
      in_last  = vecs[i].last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("vec_out_data", out_data_s, vecs[i].exp_data);
      chk("vec_out_count", cnt_s, vecs[i].exp_cnt);
      chk("vec_out_overflow", ovf_s, 0);
      chk("vec_out_valid", out_valid_s, longint'(vecs[i].last));
      if (vecs[i].last) consume();
    end

    // 300 beats of +32767: clamp versus wrap, count saturates at 255.
    pkt.delete();
    for (int i = 0; i < 300; i++) pkt.push_back('{0, 32767});
    send_packet(pkt, 1'b0);
    chk("sat_const_data", out_data_s, 8388607);
    chk("wrap_const_data", out_data_w, -6947116);
    chk("sat_const_count", cnt_s, 255);
    chk("wrap_const_ovf", ovf_w, 1);

    // Output stall with a beat continuously offered.
    in_valid = 1'b1; in_sub = 1'b0; in_data = 16'sd9; in_last = 1'b1;
    tick();
    in_data = 16'sd1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", in_ready_s, 0);
      chk("stall_out_valid", out_valid_s, 1);
      chk("stall_out_data", out_data_s, 9);
    end
    consume();
    chk("stall_release_valid", out_valid_s, 0);
    chk("stall_release_ready", in_ready_s, 1);
    chk("stall_release_data", out_data_s, 9);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("fresh_packet_data", out_data_s, 1234);
    chk("fresh_packet_count", cnt_s, 1);
    consume();

    // Asynchronous reset mid-packet.
    in_valid = 1'b1; in_sub = 1'b0; in_last = 1'b0; in_data = 16'sd10;
    tick();
    in_data = 16'sd20;
    tick();
    in_valid = 1'b0;
    chk("mid_packet_data", out_data_s, 30);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_data", out_data_s, 0);
    chk("async_rst_count", cnt_s, 0);
    chk("async_rst_wrap_data", out_data_w, 0);
    chk("async_rst_valid", out_valid_s, 0);
    #1 rst = 1'b0;
    tick();
    chk("in_ready_after_async_rst", in_ready_s, 1);
    in_valid = 1'b1; in_data = 16'sd5; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("post_rst_data", out_data_s, 5);
    chk("post_rst_count", cnt_s, 1);
    chk("post_rst_ovf", ovf_s, 0);
    consume();

    // Random packets with bubbles and stalls.
    for (int k = 0; k < 1000; k++) begin
      int  len;
      bit  neg;
      pkt.delete();
      if ($urandom_range(0, 49) == 0) begin
        len = $urandom_range(260, 300);
        neg = 1'($urandom);
        for (int i = 0; i < len; i++)
          pkt.push_back('{($urandom_range(0, 9) == 0) ? ~neg : neg,
                          32767 - int'($urandom_range(0, 2000))});
      end else begin
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++)
          pkt.push_back('{1'($urandom), int'($urandom_range(0, 65535)) - 32768});
      end
      send_packet(pkt, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
